trivium_ctrl: RTL and testbench



---
 rtl/trivium_pkg.sv | 48 ++++
 rtl/trivium_byte_shift.sv | 41 ++++
 rtl/trivium_ctrl.sv | 117 +++++++++++
 tb/tb_trivium_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium byte-stream controller.
package trivium_pkg;

  localparam int unsigned WARMUP_CYCLES = 1152;
  localparam int unsigned KEY_W         = 80;
  localparam int unsigned IV_W          = 80;
  localparam int unsigned BYTE_W        = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWarm,
    StWaitIn,
    StShift,
    StHold
  } state_e;

  // Strobes that are a pure function of the controller state.
  typedef struct packed {
    logic busy;
    logic ld;
    logic ce;
    logic in_ready;
    logic out_valid;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StLoad: begin
        c.busy = 1'b1;
        c.ld   = 1'b1;
        c.ce   = 1'b1;
      end
      StWarm: begin
        c.busy = 1'b1;
        c.ce   = 1'b1;
      end
      StWaitIn: c.in_ready  = 1'b1;
      StShift:  c.ce        = 1'b1;
      StHold:   c.out_valid = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/trivium_byte_shift.sv
// Byte shifter: parallel-load MSB-out serialiser plus serial-in collector.
module trivium_byte_shift
  import trivium_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] dat_i,
  input  logic              shift_i,
  input  logic              ser_i,
  output logic              ser_o,
  output logic [BYTE_W-1:0] res_o,
  output logic              done_o
);

  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] r_res;
  logic [2:0]        r_bit_cnt;

  // Load a byte, or move one bit out of the shifter and one bit into the collector.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift   <= '0;
      r_res     <= '0;
      r_bit_cnt <= '0;
    end else if (load_i) begin
      r_shift   <= dat_i;
      r_bit_cnt <= '0;
    end else if (shift_i) begin
      r_shift   <= {r_shift[BYTE_W-2:0], 1'b0};
      r_res     <= {r_res[BYTE_W-2:0], ser_i};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  assign ser_o  = r_shift[BYTE_W-1];
  assign res_o  = r_res;
  // High during the shift cycle that moves the eighth bit.
  assign done_o = shift_i & (r_bit_cnt == 3'd7);

endmodule

// File: rtl/trivium_ctrl.sv
// Byte-stream controller driving a bit-serial Trivium engine: load, warm-up, byte crypt.
module trivium_ctrl
  import trivium_pkg::*;
#(
  parameter int unsigned WARMUP = WARMUP_CYCLES,
  parameter int unsigned CNT_W  = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [IV_W-1:0]   iv_i,
  output logic              busy_o,
  input  logic [BYTE_W-1:0] in_dat_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [BYTE_W-1:0] out_dat_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [KEY_W-1:0]  eng_key_o,
  output logic [IV_W-1:0]   eng_iv_o,
  output logic              eng_ld_o,
  output logic              eng_ce_o,
  output logic              eng_dat_o,
  input  logic              eng_dat_i
);

  state_e            r_state;
  ctrl_t             r_ctrl;
  logic [CNT_W-1:0]  r_warm_cnt;
  logic [KEY_W-1:0]  r_key;
  logic [IV_W-1:0]   r_iv;

  state_e            w_state_nxt;
  logic              w_hs;
  logic              w_load_byte;
  logic              w_shift_en;
  logic              w_warm_last;
  logic              w_shift_done;
  logic              w_ser;
  logic [BYTE_W-1:0] w_res;

  function automatic state_e next_state(state_e st, logic start, logic hs, logic warm_last,
                                        logic shift_done, logic out_ready);
    state_e nxt;
    nxt = st;
    // A start pulse wins over everything except reset, even mid-byte.
    if (start) begin
      nxt = StLoad;
    end else begin
      case (st)
        StLoad:   nxt = StWarm;
        StWarm:   if (warm_last) nxt = StWaitIn;
        StWaitIn: if (hs) nxt = StShift;
        StShift:  if (shift_done) nxt = StHold;
        StHold:   if (out_ready) nxt = StWaitIn;
        default:  nxt = StIdle;
      endcase
    end
    return nxt;
  endfunction

  assign w_hs        = in_valid_i & r_ctrl.in_ready;
  assign w_load_byte = w_hs & ~start_i;
  assign w_shift_en  = (r_state == StShift);
  assign w_warm_last = (r_state == StWarm) && (r_warm_cnt == CNT_W'(WARMUP - 1));
  assign w_state_nxt = next_state(r_state, start_i, w_hs, w_warm_last, w_shift_done,
                                  out_ready_i);

  // Controller FSM: state, registered strobes, warm-up counter and key/IV latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_ctrl     <= '0;
      r_warm_cnt <= '0;
      r_key      <= '0;
      r_iv       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ctrl  <= ctrl_for(w_state_nxt);
      if (start_i) begin
        r_key <= key_i;
        r_iv  <= iv_i;
      end
      // Held at zero outside WARM, so it is clear on the first warm-up cycle.
      if (r_state == StWarm) begin
        r_warm_cnt <= r_warm_cnt + CNT_W'(1);
      end else begin
        r_warm_cnt <= '0;
      end
    end
  end

  trivium_byte_shift u_byte_shift (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_load_byte),
    .dat_i   (in_dat_i),
    .shift_i (w_shift_en),
    .ser_i   (eng_dat_i),
    .ser_o   (w_ser),
    .res_o   (w_res),
    .done_o  (w_shift_done)
  );

  assign busy_o      = r_ctrl.busy;
  assign in_ready_o  = r_ctrl.in_ready;
  assign out_valid_o = r_ctrl.out_valid;
  assign eng_ld_o    = r_ctrl.ld;
  assign eng_ce_o    = r_ctrl.ce;
  assign eng_key_o   = r_key;
  assign eng_iv_o    = r_iv;
  assign out_dat_o   = w_res;
  // Zero into the engine whenever no byte is being shifted.
  assign eng_dat_o   = w_shift_en & w_ser;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Scoreboard bench for trivium_ctrl with a behavioural Trivium engine attached.
module tb_trivium_ctrl;

  localparam int WARMUP = 1152;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [79:0] key_i;
  logic [79:0] iv_i;
  logic        busy_o;
  logic [7:0]  in_dat_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  out_dat_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [79:0] eng_key_o;
  logic [79:0] eng_iv_o;
  logic        eng_ld_o;
  logic        eng_ce_o;
  logic        eng_dat_o;
  logic        eng_dat_i;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_both = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [287:0] eng_s = '0;
  logic [287:0] gold_s = '0;

  always #5 clk = ~clk;

  trivium_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .key_i       (key_i),
    .iv_i        (iv_i),
    .busy_o      (busy_o),
    .in_dat_i    (in_dat_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_dat_o   (out_dat_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .eng_key_o   (eng_key_o),
    .eng_iv_o    (eng_iv_o),
    .eng_ld_o    (eng_ld_o),
    .eng_ce_o    (eng_ce_o),
    .eng_dat_o   (eng_dat_o),
    .eng_dat_i   (eng_dat_i)
  );

  // Trivium reference; state bit s(n) lives at index n-1.
  function automatic logic [287:0] triv_load(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] s;
    s = '0;
    for (int i = 0; i < 80; i++) begin
      s[i]      = k[i];
      s[93 + i] = v[i];
    end
    s[285] = 1'b1;
    s[286] = 1'b1;
    s[287] = 1'b1;
    return s;
  endfunction

  function automatic logic triv_z(input logic [287:0] s);
    return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
  endfunction

  function automatic logic [287:0] triv_step(input logic [287:0] s);
    logic [287:0] n;
    logic t1, t2, t3;
    t1 = s[65] ^ s[92] ^ (s[90] & s[91]) ^ s[170];
    t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
    t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
    n = s;
    for (int i = 92; i >= 1; i--) n[i] = s[i-1];
    n[0] = t3;
    for (int i = 176; i >= 94; i--) n[i] = s[i-1];
    n[93] = t1;
    for (int i = 287; i >= 178; i--) n[i] = s[i-1];
    n[177] = t2;
    return n;
  endfunction

  // Engine model: load has priority, otherwise advance on chip enable.
  always @(posedge clk) begin
    if (eng_ld_o) eng_s <= triv_load(eng_key_o, eng_iv_o);
    else if (eng_ce_o) eng_s <= triv_step(eng_s);
  end
  assign eng_dat_i = eng_dat_o ^ triv_z(eng_s);

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard queue.
  always @(negedge clk) begin
    if (in_ready_o && out_valid_o) n_both++;
    if (out_valid_o && out_ready_i) begin
      got_q.push_back(out_dat_o);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected out byte: got %0h, expected none", out_dat_o);
      end else begin
        chk("out byte", 80'(out_dat_o), 80'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gold_init(input logic [79:0] k, input logic [79:0] v);
    gold_s = triv_load(k, v);
    repeat (WARMUP) gold_s = triv_step(gold_s);
  endtask

  task automatic gold_byte(input logic [7:0] b, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      r[i]   = b[i] ^ triv_z(gold_s);
      gold_s = triv_step(gold_s);
    end
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n;
    n = 0;
    while (!in_ready_o && n < budget) begin
      tick();
      n++;
    end
    chk(name, 80'(in_ready_o), 80'(1));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] e);
    exp_q.push_back(e);
    in_dat_i   = b;
    in_valid_i = 1'b1;
    wait_ready(100, "in_ready for byte");
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("scoreboard drained", 80'(exp_q.size()), 80'(0));
  endtask

  task automatic do_start(input logic [79:0] k, input logic [79:0] v);
    int n;
    int ov;
    n  = 0;
    ov = 0;
    key_i   = k;
    iv_i    = v;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("ld after start", 80'(eng_ld_o), 80'(1));
    chk("ready/valid low after start", 80'({in_ready_o, out_valid_o}), 80'(0));
    gold_init(k, v);
    while (!in_ready_o && n < 1300) begin
      ov += int'(out_valid_o);
      tick();
      n++;
    end
    chk("ready after warm-up", 80'(in_ready_o), 80'(1));
    chk("no out_valid during restart", 80'(ov), 80'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ce_cnt, ld_cnt, busy_cnt, ce_first, ce_last, rdy_first, chg, lost;
    int          n;
    logic [7:0]  e;
    logic [7:0]  held;
    logic [7:0]  c [3];
    logic [7:0]  pt [3];

    pt[0] = 8'hA5;
    pt[1] = 8'h00;
    pt[2] = 8'hFF;
    c[0] = '0;
    c[1] = '0;
    c[2] = '0;
    rst_i = 1'b1; start_i = 1'b0; key_i = '0; iv_i = '0;
    in_dat_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) tick();

    // Reset values.
    chk("reset eng_key", eng_key_o, 80'(0));
    chk("reset eng_iv", eng_iv_o, 80'(0));
    chk("reset strobes", 80'({busy_o, in_ready_o, out_valid_o, eng_ld_o, eng_ce_o, eng_dat_o}),
        80'(0));
    chk("reset out_dat", 80'(out_dat_o), 80'(0));
    rst_i  = 1'b0;
    ce_cnt = 0;
    repeat (50) begin
      tick();
      ce_cnt += int'(eng_ce_o);
    end
    chk("idle ce count", 80'(ce_cnt), 80'(0));

    // Start with zero key/IV and profile the load/warm-up timeline.
    key_i = '0; iv_i = '0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    ld_cnt = 0; ce_cnt = 0; busy_cnt = 0; ce_first = -1; ce_last = -1; rdy_first = -1;
    for (int k = 1; k <= 1200; k++) begin
      if (eng_ld_o) ld_cnt++;
      if (eng_ce_o) begin
        ce_cnt++;
        if (ce_first < 0) ce_first = k;
        ce_last = k;
      end
      if (busy_o) busy_cnt++;
      if (in_ready_o && rdy_first < 0) rdy_first = k;
      tick();
    end
    chk("ld cycles", 80'(ld_cnt), 80'(1));
    chk("ce cycles", 80'(ce_cnt), 80'(1153));
    chk("ce first cycle", 80'(ce_first), 80'(1));
    chk("ce last cycle", 80'(ce_last), 80'(1153));
    chk("in_ready first cycle", 80'(rdy_first), 80'(1154));
    chk("busy cycles", 80'(busy_cnt), 80'(1153));
    gold_init('0, '0);

    // Encrypt three bytes and keep the ciphertext.
    for (int i = 0; i < 3; i++) begin
      gold_byte(pt[i], e);
      send_byte(pt[i], e);
    end
    drain();
    chk("ciphertext count", 80'(got_q.size()), 80'(3));
    for (int i = 0; i < 3; i++) if (got_q.size() != 0) c[i] = got_q.pop_front();

    // Stall in HOLD: keystream must not advance and data must stay put.
    out_ready_i = 1'b0;
    gold_byte(8'h3C, e);
    send_byte(8'h3C, e);
    n = 0;
    while (!out_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("hold reached", 80'(out_valid_o), 80'(1));
    held = out_dat_o; ce_cnt = 0; chg = 0; lost = 0;
    repeat (20) begin
      tick();
      ce_cnt += int'(eng_ce_o);
      if (out_dat_o !== held) chg++;
      if (!out_valid_o) lost++;
    end
    chk("hold ce count", 80'(ce_cnt), 80'(0));
    chk("hold data changes", 80'(chg), 80'(0));
    chk("hold valid drops", 80'(lost), 80'(0));
    out_ready_i = 1'b1;
    gold_byte(8'h5A, e);
    send_byte(8'h5A, e);
    drain();

    // Decrypt: same key/IV, feed ciphertext back.
    do_start('0, '0);
    for (int i = 0; i < 3; i++) send_byte(c[i], pt[i]);
    drain();

    // Abort mid-byte at bit 4 with a new key.
    in_dat_i = 8'h77; in_valid_i = 1'b1;
    wait_ready(50, "ready before abort byte");
    tick();
    in_valid_i = 1'b0;
    repeat (4) tick();
    chk("shifting at bit 4", 80'(eng_ce_o), 80'(1));
    do_start(80'h0123_4567_89AB_CDEF_0123, 80'hFEDC_BA98_7654_3210_A5A5);
    gold_byte(8'h11, e);
    send_byte(8'h11, e);
    gold_byte(8'hEE, e);
    send_byte(8'hEE, e);
    drain();

    // Reset in the middle of warm-up.
    key_i = 80'h1357_9BDF_0246_8ACE_1122; iv_i = 80'h3344_5566_7788_99AA_BBCC;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (599) tick();
    chk("warm at cycle 600", 80'({busy_o, eng_ce_o}), 80'(2'b11));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("post-reset strobes", 80'({busy_o, in_ready_o, out_valid_o, eng_ld_o, eng_ce_o}),
        80'(0));
    chk("post-reset eng_key", eng_key_o, 80'(0));
    ce_cnt = 0;
    repeat (100) begin
      tick();
      ce_cnt += int'(eng_ce_o);
    end
    chk("post-reset ce count", 80'(ce_cnt), 80'(0));
    do_start(80'h1357_9BDF_0246_8ACE_1122, 80'h3344_5566_7788_99AA_BBCC);
    gold_byte(8'h42, e);
    send_byte(8'h42, e);
    drain();

    chk("ready/valid overlap cycles", 80'(n_both), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
